// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Instruction handshake bundle between an instruction source
//                (fetch logic or a testbench) and alu_sequencer.
//                  instr_valid : source -> sequencer, instr holds a valid word
//                  instr       : source -> sequencer, 16-bit instruction word
//                  instr_ready : sequencer -> source, word accepted this cycle
//                A transfer happens on a rising clock edge where both
//                instr_valid and instr_ready are high.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    // Instruction source side
    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    // Sequencer side
    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle controller for the ALU / register-file datapath.
//                Accepts one 16-bit instruction per valid/ready handshake and
//                steps through OPB (operand B select), OPA (operand A select)
//                and EXEC (execute + write-back). Counts retired instructions.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous reset, active low
//                instr_if     - instruction handshake (slave side)
//                hold         - freezes state, IR and retire counter
//                control1     - operand A select (0 = none, r+1 = register r)
//                control2     - operand B select (same encoding)
//                imm_control  - selects immediate as operand B
//                immediate    - sign-extended imm8
//                opcode       - ALU operation code
//                buff_en      - drives ALU result onto write-back bus
//                enable       - one-hot register write enable
//                done         - one-cycle pulse when an instruction retires
//                retire_count - retired instruction count (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_sequencer_if.slave     instr_if,
    input  wire logic          hold,
    output logic [4:0]         control1,
    output logic [4:0]         control2,
    output logic               imm_control,
    output logic [WIDTH-1:0]   immediate,
    output logic [7:0]         opcode,
    output logic               buff_en,
    output logic [NUM_REGS-1:0] enable,
    output logic               done,
    output logic [WIDTH-1:0]   retire_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_opb  = 2'd1;
    localparam logic [1:0] c_st_opa  = 2'd2;
    localparam logic [1:0] c_st_exec = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [15:0]         r_ir;
    logic [WIDTH-1:0]    r_retire_count;

    logic                w_handshake;
    logic [3:0]          w_op;
    logic [3:0]          w_rdst;
    logic [3:0]          w_ext;
    logic [3:0]          w_rsrc;
    logic [7:0]          w_imm8;
    logic                w_is_rtype;
    logic                w_is_cmp;
    logic                w_is_nop;
    logic [WIDTH-1:0]    w_imm_sext;
    logic [NUM_REGS-1:0] w_dst_onehot;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    assign w_op       = r_ir[15:12];
    assign w_rdst     = r_ir[11:8];
    assign w_ext      = r_ir[7:4];
    assign w_rsrc     = r_ir[3:0];
    assign w_imm8     = r_ir[7:0];
    assign w_is_rtype = (w_op == 4'h0);
    assign w_is_cmp   = w_is_rtype && (w_ext == 4'hB);
    assign w_is_nop   = (w_op == 4'hF);

    // Destinations at or beyond NUM_REGS shift out and produce no write.
    assign w_dst_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_rdst;

    generate
        if (WIDTH > 8) begin : g_imm_wide
            assign w_imm_sext = {{(WIDTH-8){w_imm8[7]}}, w_imm8};
        end else begin : g_imm_narrow
            assign w_imm_sext = w_imm8[WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: reset is folded in so ready is low while reset is held.
    // ------------------------------------------------------------------
    assign instr_if.instr_ready = ((r_state == c_st_idle) || (r_state == c_st_exec))
                                  && !hold && reset;
    assign w_handshake = instr_if.instr_valid && instr_if.instr_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Hold freezes the current state; a handshake
    // can only occur when hold is low, since ready already excludes it.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_handshake) w_next_state = c_st_opb;
            c_st_opb:  if (!hold)       w_next_state = c_st_opa;
            c_st_opa:  if (!hold)       w_next_state = c_st_exec;
            c_st_exec: begin
                if (!hold) begin
                    w_next_state = w_handshake ? c_st_opb : c_st_idle;
                end
            end
            default:   w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore output decode of state and IR. Select outputs stay valid
    // during hold; the write strobes and done are suppressed under hold so
    // the write lands in the first EXEC cycle with hold low.
    // ------------------------------------------------------------------
    always_comb begin
        control1    = 5'd0;
        control2    = 5'd0;
        imm_control = 1'b0;
        immediate   = '0;
        opcode      = 8'h00;
        buff_en     = 1'b0;
        enable      = '0;
        done        = 1'b0;
        case (r_state)
            c_st_opb: begin
                if (!w_is_nop) begin
                    if (w_is_rtype) begin
                        control2 = {1'b0, w_rsrc} + 5'd1;
                    end else begin
                        imm_control = 1'b1;
                        immediate   = w_imm_sext;
                    end
                end
            end
            c_st_opa: begin
                if (!w_is_nop) begin
                    control1 = {1'b0, w_rdst} + 5'd1;
                end
            end
            c_st_exec: begin
                if (!w_is_nop) begin
                    opcode = w_is_rtype ? {4'h0, w_ext} : {w_op, 4'h0};
                end
                if (!hold) begin
                    done = 1'b1;
                    if (!w_is_nop && !w_is_cmp) begin
                        buff_en = 1'b1;
                        enable  = w_dst_onehot;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= 16'h0000;
        end else if (w_handshake) begin
            r_ir <= instr_if.instr;
        end
    end

    // ------------------------------------------------------------------
    // Retire counter; done is already gated by hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_count <= '0;
        end else if (done) begin
            r_retire_count <= r_retire_count + WIDTH'(1);
        end
    end

    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. A per-cycle vector
//                table drives the handshake/hold inputs and holds the
//                expected outputs; hand-written sequences cover reset in the
//                middle of an instruction and retire-counter wrap (on a
//                second, 8-bit wide instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic clk;
    logic reset;
    logic hold;
    logic hold_w;

    alu_sequencer_if bus();
    alu_sequencer_if bus_w();

    logic [4:0]  control1, control2;
    logic        imm_control;
    logic [15:0] immediate;
    logic [7:0]  opcode;
    logic        buff_en;
    logic [15:0] enable;
    logic        done;
    logic [15:0] retire_count;

    logic [4:0]  control1_w, control2_w;
    logic        imm_control_w;
    logic [7:0]  immediate_w;
    logic [7:0]  opcode_w;
    logic        buff_en_w;
    logic [15:0] enable_w;
    logic        done_w;
    logic [7:0]  retire_count_w;

    alu_sequencer #(.NUM_REGS(16), .WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_if     (bus.slave),
        .hold         (hold),
        .control1     (control1),
        .control2     (control2),
        .imm_control  (imm_control),
        .immediate    (immediate),
        .opcode       (opcode),
        .buff_en      (buff_en),
        .enable       (enable),
        .done         (done),
        .retire_count (retire_count)
    );

    alu_sequencer #(.NUM_REGS(16), .WIDTH(8)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .instr_if     (bus_w.slave),
        .hold         (hold_w),
        .control1     (control1_w),
        .control2     (control2_w),
        .imm_control  (imm_control_w),
        .immediate    (immediate_w),
        .opcode       (opcode_w),
        .buff_en      (buff_en_w),
        .enable       (enable_w),
        .done         (done_w),
        .retire_count (retire_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] instr;
        logic        hold;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        imm_c;
        logic [15:0] imm;
        logic [7:0]  opc;
        logic        buff;
        logic [15:0] en;
        logic        dn;
        logic        rdy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Packed view: {c1,c2,imm_c,imm,opc,buff,en,done,ready,count}
    function automatic logic [69:0] actual();
        return {control1, control2, imm_control, immediate, opcode,
                buff_en, enable, done, bus.instr_ready, retire_count};
    endfunction

    function automatic logic [69:0] pack(input vec_t v);
        return {v.c1, v.c2, v.imm_c, v.imm, v.opc, v.buff, v.en, v.dn, v.rdy, v.cnt};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h ({c1,c2,immc,imm,opc,buff,en,done,rdy,cnt})",
                     name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [15:0] ins, input logic hld,
                       input logic [4:0] c1, input logic [4:0] c2, input logic ic,
                       input logic [15:0] im, input logic [7:0] op, input logic be,
                       input logic [15:0] en, input logic dn, input logic rd,
                       input logic [15:0] cnt);
        vec_t v;
        v.valid = vld; v.instr = ins; v.hold = hld;
        v.c1 = c1; v.c2 = c2; v.imm_c = ic; v.imm = im; v.opc = op;
        v.buff = be; v.en = en; v.dn = dn; v.rdy = rd; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Expected output vector with every datapath output 0
    function automatic logic [69:0] idle_exp(input logic rdy, input logic [15:0] cnt);
        return {5'd0, 5'd0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 1'b0, rdy, cnt};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        hold_w = 1'b0;
        bus.instr_valid   = 1'b0;
        bus.instr         = 16'h0000;
        bus_w.instr_valid = 1'b0;
        bus_w.instr       = 16'h0000;

        //   vld instr      hld c1 c2 ic imm       opc   be en        dn rdy cnt
        // R-type 0253
        add(1, 16'h0253, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 0);
        add(0, 16'h0000, 0,  0, 4, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 0,  3, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h05, 1, 16'h0004, 1, 1, 0);
        // I-type 51F6
        add(1, 16'h51F6, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 1);
        add(0, 16'h0000, 0,  0, 0, 1, 16'hFFF6, 8'h00, 0, 16'h0000, 0, 0, 1);
        add(0, 16'h0000, 0,  2, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 1);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h50, 1, 16'h0002, 1, 1, 1);
        // Back-to-back 0253 then 0314 (valid held high)
        add(1, 16'h0253, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 2);
        add(1, 16'h0314, 0,  0, 4, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 2);
        add(1, 16'h0314, 0,  3, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 2);
        add(1, 16'h0314, 0,  0, 0, 0, 16'h0000, 8'h05, 1, 16'h0004, 1, 1, 2);
        add(0, 16'h0000, 0,  0, 5, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 3);
        add(0, 16'h0000, 0,  4, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 3);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h01, 1, 16'h0008, 1, 1, 3);
        // CMP 04B7
        add(1, 16'h04B7, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 4);
        add(0, 16'h0000, 0,  0, 8, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 4);
        add(0, 16'h0000, 0,  5, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 4);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h0B, 0, 16'h0000, 1, 1, 4);
        // Hold for 2 cycles in EXEC of 0253
        add(1, 16'h0253, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 5);
        add(0, 16'h0000, 0,  0, 4, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 5);
        add(0, 16'h0000, 0,  3, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 5);
        add(0, 16'h0000, 1,  0, 0, 0, 16'h0000, 8'h05, 0, 16'h0000, 0, 0, 5);
        add(0, 16'h0000, 1,  0, 0, 0, 16'h0000, 8'h05, 0, 16'h0000, 0, 0, 5);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h05, 1, 16'h0004, 1, 1, 5);
        // NOP F000
        add(1, 16'hF000, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 6);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 6);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 6);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 1, 6);
        // hold + valid in IDLE: no handshake; then hold in OPB
        add(1, 16'h0253, 1,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 7);
        add(1, 16'h0253, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 7);
        add(0, 16'h0000, 1,  0, 4, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 7);
        add(0, 16'h0000, 0,  0, 4, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 7);
        add(0, 16'h0000, 0,  3, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 0, 7);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h05, 1, 16'h0004, 1, 1, 7);
        add(0, 16'h0000, 0,  0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 0, 1, 8);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", actual(), idle_exp(1'b0, 16'h0000));

        @(negedge clk);
        reset = 1'b1;

        // Table-driven section
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.instr_valid = vecs[i].valid;
            bus.instr       = vecs[i].instr;
            hold            = vecs[i].hold;
            #1;
            check($sformatf("vec%0d", i), actual(), pack(vecs[i]));
        end

        // Reset asserted in the OPA cycle of an in-flight instruction
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0253;
        hold            = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_opa", actual(), {5'd3, 5'd0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0, 16'd8});
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", actual(), idle_exp(1'b0, 16'h0000));
        @(negedge clk);
        #1;
        check("reset_held", actual(), idle_exp(1'b0, 16'h0000));
        reset = 1'b1;
        #1;
        check("reset_release", actual(), idle_exp(1'b1, 16'h0000));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("no_done_%0d", k), actual(), idle_exp(1'b1, 16'h0000));
        end

        // Wrap of the retire counter on the 8-bit instance
        @(negedge clk);
        bus_w.instr       = 16'h0253;
        bus_w.instr_valid = 1'b1;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            #1;
            if (retire_count_w == 8'hFF) break;
        end
        check8("wrap_preload", retire_count_w, 8'hFF);
        bus_w.instr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done_w) break;
            @(negedge clk);
            #1;
        end
        check8("wrap_done", {7'd0, done_w}, 8'h01);
        @(negedge clk);
        #1;
        check8("wrap_zero", retire_count_w, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the ALU register-file datapath. It accepts one 16-bit instruction per valid/ready handshake and steps the datapath through three phases: operand B select, operand A select, then execute and write-back. It drives every datapath control input and sits between the instruction source (fetch logic or testbench) and the datapath. It also counts retired instructions.

## Interface
Parameters:
- `NUM_REGS`, default 16: register-file depth; register index r is selected by mux code r+1.
- `WIDTH`, default 16: datapath, immediate and retire-counter width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  the instruction on `instr` is valid.
- `instr_ready`  out  1  the sequencer can accept an instruction this cycle.
- `instr`  in  16  instruction word, fields as listed under Operation.
- `hold`  in  1  freezes the sequencer.
- `control1`  out  5  operand-A register select: 0 = none, r+1 = register r.
- `control2`  out  5  operand-B register select, same encoding as `control1`.
- `imm_control`  out  1  selects `immediate` as operand B.
- `immediate`  out  WIDTH  sign-extended immediate.
- `opcode`  out  8  ALU operation code.
- `buff_en`  out  1  drives the ALU result onto the write-back bus.
- `enable`  out  NUM_REGS  one-hot register write enable.
- `done`  out  1  one-cycle pulse in the EXEC cycle that retires an instruction.
- `retire_count`  out  WIDTH  number of retired instructions; wraps around.

## Operation
Instruction fields:
- `op` = instr[15:12]; `rdst` = instr[11:8]; `ext` = instr[7:4]; `rsrc` = instr[3:0]; `imm8` = instr[7:0].

Instruction classes:
- R-type (`op`=0): operand B = register `rsrc`; `opcode` = {4'h0, `ext`}.
- CMP (`op`=0, `ext`=4'hB): R-type with no write-back. `enable`=0 and `buff_en`=0 in EXEC; `done` still pulses.
- I-type (`op`=1..4'hE): operand B = `imm8` sign-extended to WIDTH; `opcode` = {`op`, 4'h0}.
- NOP (`op`=4'hF): traverses all states, but every datapath output is 0 in every state; `done` pulses and the instruction is counted.

State machine: IDLE, OPB, OPA, EXEC.
- Handshake: `instr` is latched into an internal IR on `instr_valid` && `instr_ready` at the clock edge.
- IDLE: all datapath outputs 0. A handshake moves the FSM to OPB.
- OPB:
  - R-type: `control2`=`rsrc`+1.
  - I-type: `imm_control`=1 and `immediate`=sext(`imm8`).
  - Always moves to OPA.
- OPA: `control1`=`rdst`+1; always moves to EXEC.
- EXEC:
  - Drives `opcode`, `buff_en`=1, `enable`=1<<`rdst`, `done`=1.
  - A handshake in EXEC loads the next instruction and moves to OPB; otherwise the FSM returns to IDLE.
- Datapath outputs are a Moore decode of the state and IR; any output not listed for a state is 0.
- `instr_ready` = (state is IDLE or EXEC) && !`hold` && `reset`.
- `retire_count` increments by 1 on every clock edge where `done`=1 and wraps from all-ones to 0.

Hold:
- While `hold`=1, the state, IR and `retire_count` are frozen and `instr_ready`=0.
- Select outputs (`control1`, `control2`, `imm_control`, `immediate`, `opcode`) keep their current-state values.
- In EXEC, `buff_en`, `enable` and `done` are forced to 0 while `hold`=1, so no write occurs and nothing is counted. The write happens in the first EXEC cycle with `hold`=0.

## Timing
- Reset: while `reset`=0, the state is IDLE, IR=0, `retire_count`=0, and every output including `instr_ready` is 0. The reset takes effect immediately, including mid-instruction; the in-flight instruction is dropped and not counted.
- After reset is released, `instr_ready`=1 in the first cycle, provided `hold`=0.
- Latency: a handshake at edge N gives OPB in cycle N+1, OPA in N+2 and EXEC (write, `done`) in N+3.
- Throughput: back-to-back issue retires one instruction every 3 cycles.
- `instr_valid` without `instr_ready` is ignored; the source holds `instr` until the handshake.
- `hold` and `instr_valid` asserted together: no handshake takes place.

## Test plan
- Reset: assert `reset`=0 in the OPA cycle of an instruction. All outputs go to 0 immediately and `retire_count`=0. Release reset: `instr_ready`=1, and no `done` appears for the dropped instruction.
- R-type 16'h0253:
  - OPB: `control2`=5'd4.
  - OPA: `control1`=5'd3.
  - EXEC: `opcode`=8'h05, `buff_en`=1, `enable`=16'h0004, `done`=1.
  - Then `retire_count`=1.
- I-type 16'h51F6:
  - OPB: `imm_control`=1, `immediate`=16'hFFF6.
  - OPA: `control1`=5'd2.
  - EXEC: `opcode`=8'h50, `enable`=16'h0002.
- Back-to-back: `instr_valid` held high with 16'h0253 then 16'h0314. `done` pulses at cycles 3 and 6 and `retire_count`=2. The second EXEC gives `enable`=16'h0008 and `opcode`=8'h01.
- CMP 16'h04B7: OPB `control2`=5'd8; EXEC `opcode`=8'h0B, `buff_en`=0, `enable`=0, `done`=1.
- Hold and NOP:
  - Hold asserted for 2 cycles in the EXEC of 16'h0253: `enable`=0 and `done`=0 for those 2 cycles. After release, one EXEC cycle with `enable`=16'h0004 and a count of +1.
  - NOP 16'hF000: 3 cycles with all datapath outputs 0, `done`=1 in the third cycle, count +1.
- Wrap: preload `retire_count` by running to 16'hFFFF, then retire one more instruction: `retire_count`=16'h0000.
